uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-003 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-004 SHALL have port rx_baud, input, 3 bits: baud select using the same encoding as the transmitter.
REQ-005 SHALL have port rx_dat, output, 8 bits: last received byte.
REQ-006 SHALL have port rx_ok, output, 1 bit: one-cycle pulse when a valid byte is available.
REQ-007 SHALL have port rx_err, output, 1 bit: one-cycle pulse on a frame error (stop bit low).
REQ-008 SHALL have port rx_ing, output, 1 bit: high while a frame is being received.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-010 SHALL map rx_baud to divisor N: 0->2603, 1->10415, 2->5207, 3->2603, 4->1301, 5->650, 6->433, 7->216.
REQ-011 SHALL use a bit period P = N+1 clocks and a 14-bit count.
REQ-012 SHALL latch N at start-bit detection; changes to rx_baud mid-frame SHALL NOT affect the current frame.
REQ-013 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: a synchronized high->low transition SHALL go to START, clear the counter, and set rx_ing.
REQ-015 START: at count floor(P/2)-1, sample the line; if high (glitch), return to IDLE with rx_ing low and no pulse; if low, restart the counter and go to DATA.
REQ-016 DATA: every P clocks, sample one bit, LSB first; after 8 bits, go to STOP.
REQ-017 STOP: after P clocks, sample the line.
REQ-018 If the stop sample is high: load rx_dat, pulse rx_ok for 1 cycle, and return to IDLE.
REQ-019 If the stop sample is low: pulse rx_err for 1 cycle, leave rx_dat unchanged, and wait in STOP until the line is high before returning to IDLE (break handling).
REQ-020 rx_ing SHALL drop in the same cycle that rx_ok or rx_err asserts.
REQ-021 rx_ok and rx_err SHALL never assert together.
REQ-022 Latency: rx_ok SHALL assert within 2 synchronizer cycles + 1 clock of the mid-stop-bit point.
REQ-023 A falling edge seen during STOP (after a valid stop sample) SHALL be detected in IDLE on the next cycle, with no frame lost for back-to-back frames.
REQ-024 The shift register SHALL be internal; rx_dat SHALL update only on rx_ok.

Reset
REQ-025 rst SHALL force: FSM to IDLE, counters to 0, synchronizer flops to 1, rx_dat=8'h00, rx_ok=0, rx_err=0, rx_ing=0.
REQ-026 Reset mid-frame SHALL abandon the frame with no pulse; reception SHALL resume on the next falling edge after rst deasserts.

Configuration
REQ-027 Macro UART_RX_MAJORITY_EN defined: each bit (start, data, stop) SHALL be a 2-of-3 majority of samples at mid-1, mid, and mid+1 clocks, with the decision at mid+1; all timing otherwise identical.
REQ-028 Macro UART_RX_MAJORITY_EN undefined: a single sample SHALL be taken at mid.

Structure
REQ-029 Package uart_pkg SHALL hold the baud divisor constants and the FSM state typedef, shared with uart_tx.
REQ-030 Sub-module uart_baud_gen SHALL take divisor N plus enable/clear, and output the count and tick; uart_rx instantiates it once.

Verification
REQ-031 rx_baud=7, frame 0x55 at 217 clk/bit -> rx_dat=0x55, one rx_ok pulse, rx_err never asserts.
REQ-032 rx_baud=3, frame 0xA3 then 0x3C back-to-back with no idle gap -> two rx_ok pulses, rx_dat=0xA3 then 0x3C.
REQ-033 rx_baud=7, stop bit driven low on byte 0xFF -> one rx_err pulse, no rx_ok, rx_dat unchanged; line held low 5000 clk then high -> next byte received correctly.
REQ-034 rx_baud=7, low glitch of 50 clk on an idle line -> return to IDLE, rx_ing drops, no rx_ok and no rx_err.
REQ-035 rx_baud=5, rst asserted during data bit 4 -> all outputs reset; next frame 0x81 -> rx_ok with rx_dat=0x81.
REQ-036 UART_RX_MAJORITY_EN defined, rx_baud=7, 1-clk inverted spike at the mid-sample of each data bit of 0x5A -> rx_dat=0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors, counter width and the receive FSM
// state type. uart_tx imports the same package so that both directions decode
// the baud select identically.
package uart_pkg;

  localparam int CNT_W = 14;

  // Divisor N per baud select; one bit lasts N+1 clocks.
  localparam logic [CNT_W-1:0] DIV_SEL0 = 14'd2603;
  localparam logic [CNT_W-1:0] DIV_SEL1 = 14'd10415;
  localparam logic [CNT_W-1:0] DIV_SEL2 = 14'd5207;
  localparam logic [CNT_W-1:0] DIV_SEL3 = 14'd2603;
  localparam logic [CNT_W-1:0] DIV_SEL4 = 14'd1301;
  localparam logic [CNT_W-1:0] DIV_SEL5 = 14'd650;
  localparam logic [CNT_W-1:0] DIV_SEL6 = 14'd433;
  localparam logic [CNT_W-1:0] DIV_SEL7 = 14'd216;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [CNT_W-1:0] baud_div(input logic [2:0] sel);
    logic [CNT_W-1:0] n;
    case (sel)
      3'd0:    n = DIV_SEL0;
      3'd1:    n = DIV_SEL1;
      3'd2:    n = DIV_SEL2;
      3'd3:    n = DIV_SEL3;
      3'd4:    n = DIV_SEL4;
      3'd5:    n = DIV_SEL5;
      3'd6:    n = DIV_SEL6;
      default: n = DIV_SEL7;
    endcase
    return n;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter. Counts 0..div while enabled and wraps to 0, raising tick
// on the terminal count, so one tick marks every div+1 clocks. clr forces the
// count back to 0 and takes priority over counting.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear, wrap on terminal count, or advance
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == div) cnt_d = '0;
      else              cnt_d = cnt_q + 14'd1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign tick = en & ~clr & (cnt_q == div);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, baud from uart_pkg::baud_div.
// Optional build macro UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote of the
// samples at mid-1, mid and mid+1, decided at mid+1. Without it a single
// sample at mid is used.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a synchronized falling edge
// ST_START | timing to mid start bit; a high sample there is a glitch
// ST_DATA  | one sample per bit period, 8 bits shifted in LSB first
// ST_STOP  | sample stop bit; on a low stop (brk_q) wait for line high
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [2:0] rx_baud,
  output logic [7:0] rx_dat,
  output logic       rx_ok,
  output logic       rx_err,
  output logic       rx_ing
);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             brk_q, brk_d;
  logic             rx_s1_q, rx_s1_d;
  logic             rx_s2_q, rx_s2_d;
  logic             rx_prev_q, rx_prev_d;
  logic [7:0]       rx_dat_q, rx_dat_d;
  logic             rx_ok_q, rx_ok_d;
  logic             rx_err_q, rx_err_d;
  logic             rx_ing_q, rx_ing_d;
`ifdef UART_RX_MAJORITY_EN
  logic             v0_q, v0_d;
  logic             v1_q, v1_d;
`endif

  logic             bg_en, bg_clr, bg_tick;
  logic [CNT_W-1:0] bg_cnt;
  logic [CNT_W-1:0] half_m1;
  logic             start_pt;
  logic             smp;
  logic             fall;

  uart_baud_gen u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (bg_en),
    .clr  (bg_clr),
    .div  (div_q),
    .cnt  (bg_cnt),
    .tick (bg_tick)
  );

  // next-state, sampling and output pulse decode
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    brk_d     = brk_q;
    rx_dat_d  = rx_dat_q;
    rx_ok_d   = 1'b0;
    rx_err_d  = 1'b0;
    rx_ing_d  = rx_ing_q;
    rx_s1_d   = rx;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
    bg_clr    = 1'b0;
    bg_en     = (state_q != ST_IDLE) && !brk_q;
    fall      = rx_prev_q & ~rx_s2_q;
    half_m1   = ((div_q + 14'd1) >> 1) - 14'd1;

`ifdef UART_RX_MAJORITY_EN
    // Vote samples are captured one and two clocks ahead of the decision
    // point; the decision itself uses the live synchronized value.
    v0_d     = v0_q;
    v1_d     = v1_q;
    start_pt = (bg_cnt == half_m1 + 14'd1);
    smp      = maj3(v0_q, v1_q, rx_s2_q);
    if (state_q == ST_START) begin
      if (bg_cnt == half_m1 - 14'd1) v0_d = rx_s2_q;
      if (bg_cnt == half_m1)         v1_d = rx_s2_q;
    end else if (bg_en) begin
      if (bg_cnt == div_q - 14'd2) v0_d = rx_s2_q;
      if (bg_cnt == div_q - 14'd1) v1_d = rx_s2_q;
    end
`else
    start_pt = (bg_cnt == half_m1);
    smp      = rx_s2_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d   = ST_START;
          bg_clr    = 1'b1;
          div_d     = baud_div(rx_baud);
          bit_cnt_d = 3'd0;
          rx_ing_d  = 1'b1;
        end
      end
      ST_START: begin
        if (start_pt) begin
          if (smp) begin
            state_d  = ST_IDLE;
            rx_ing_d = 1'b0;
          end else begin
            state_d = ST_DATA;
            bg_clr  = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (bg_tick) begin
          sh_d      = {smp, sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (brk_q) begin
          if (rx_s2_q) begin
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (bg_tick) begin
          rx_ing_d = 1'b0;
          if (smp) begin
            rx_ok_d  = 1'b1;
            rx_dat_d = sh_q;
            state_d  = ST_IDLE;
          end else begin
            rx_err_d = 1'b1;
            brk_d    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and registered outputs; synchronizer resets to idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      sh_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      brk_q     <= 1'b0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_dat_q  <= 8'h00;
      rx_ok_q   <= 1'b0;
      rx_err_q  <= 1'b0;
      rx_ing_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      v0_q      <= 1'b1;
      v1_q      <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      brk_q     <= brk_d;
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_prev_q <= rx_prev_d;
      rx_dat_q  <= rx_dat_d;
      rx_ok_q   <= rx_ok_d;
      rx_err_q  <= rx_err_d;
      rx_ing_q  <= rx_ing_d;
`ifdef UART_RX_MAJORITY_EN
      v0_q      <= v0_d;
      v1_q      <= v1_d;
`endif
    end
  end

  assign rx_dat = rx_dat_q;
  assign rx_ok  = rx_ok_q;
  assign rx_err = rx_err_q;
  assign rx_ing = rx_ing_q;

endmodule
